// File: rtl/i2s_sync_transmitter_if.sv
// Sample-pair handshake between a sample source and the I2S transmitter.
// The source (master) offers a stereo pair with in_valid; the transmitter
// (slave) takes it when its one-deep holding register is empty.
interface i2s_sync_transmitter_if #(
    parameter int DATA_WIDTH = 24
) ();
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_left;
    logic signed [DATA_WIDTH-1:0] in_right;

    modport master (
        output in_valid,
        output in_left,
        output in_right,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_left,
        input  in_right,
        output in_ready
    );
endinterface

// File: rtl/i2s_sync_transmitter.sv
// I2S serial transmitter slaved to an external bit clock and word select.
// sck/ws are oversampled in the system clock domain; a channel change seen on
// a bit-clock rising edge loads the next slot, and bits leave MSB first on the
// following falling edges. Samples come through a one-deep holding register.
module i2s_sync_transmitter #(
    parameter int DATA_WIDTH  = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         sck_in,
    input  logic                         ws_in,
    i2s_sync_transmitter_if.slave        sample_bus,
    output logic                         sd_out,
    output logic                         frame_start,
    output logic                         underrun
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,   // no bit-clock rising edge seen since reset
        ST_ARMED,  // ws reference captured, waiting for a channel change
        ST_RUN     // slots are being serialized
    } state_t;

    state_t                       state;
    logic [SYNC_STAGES-1:0]       sck_sync_p0;
    logic [SYNC_STAGES-1:0]       ws_sync_p0;
    logic                         sck_hist_p0;
    logic                         rise_p1;
    logic                         fall_p1;
    logic                         ws_p1;
    logic                         ws_prev;
    logic                         hold_full;
    logic                         accept;
    logic signed [DATA_WIDTH-1:0] hold_left;
    logic signed [DATA_WIDTH-1:0] hold_right;
    logic signed [DATA_WIDTH-1:0] act_right;
    logic        [DATA_WIDTH-1:0] shift_reg;
    logic        [CNT_W-1:0]      bit_cnt;

    // Bit counter stops at the slot width so trailing bits stay at zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (cnt >= CNT_MAX)
            return CNT_MAX;
        return cnt + 1'b1;
    endfunction

    assign sample_bus.in_ready = ~hold_full;
    assign accept              = sample_bus.in_valid & ~hold_full;

    // Stage p0: bring sck/ws into the clock domain and keep one sck history bit.
    always_ff @(posedge clock) begin
        sck_sync_p0 <= {sck_sync_p0[SYNC_STAGES-2:0], sck_in};
        ws_sync_p0  <= {ws_sync_p0[SYNC_STAGES-2:0], ws_in};
        sck_hist_p0 <= sck_sync_p0[SYNC_STAGES-1];
    end

    // Stage p1: register single-cycle edge strobes with ws aligned to them.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rise_p1 <= 1'b0;
            fall_p1 <= 1'b0;
        end else begin
            rise_p1 <= sck_sync_p0[SYNC_STAGES-1] & ~sck_hist_p0;
            fall_p1 <= ~sck_sync_p0[SYNC_STAGES-1] & sck_hist_p0;
        end
        ws_p1 <= ws_sync_p0[SYNC_STAGES-1];
    end

    // Holding register payload; occupancy is tracked by hold_full below.
    always_ff @(posedge clock) begin
        if (accept) begin
            hold_left  <= sample_bus.in_left;
            hold_right <= sample_bus.in_right;
        end
    end

    // Stage p2: arming FSM, slot loading, handshake occupancy and serializer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= ST_IDLE;
            ws_prev     <= 1'b0;
            hold_full   <= 1'b0;
            act_right   <= '0;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            sd_out      <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            // A left load only clears a full register, an accept only fills
            // an empty one, so the two never collide on hold_full.
            if (accept)
                hold_full <= 1'b1;
            if (rise_p1) begin
                case (state)
                    ST_IDLE: begin
                        ws_prev <= ws_p1;
                        state   <= ST_ARMED;
                    end
                    default: begin
                        if (ws_p1 != ws_prev) begin
                            ws_prev <= ws_p1;
                            state   <= ST_RUN;
                            bit_cnt <= '0;
                            if (!ws_p1) begin
                                frame_start <= 1'b1;
                                if (hold_full) begin
                                    shift_reg <= hold_left;
                                    act_right <= hold_right;
                                    hold_full <= 1'b0;
                                end else begin
                                    shift_reg <= '0;
                                    act_right <= '0;
                                    underrun  <= 1'b1;
                                end
                            end else begin
                                shift_reg <= act_right;
                            end
                        end
                    end
                endcase
            end else if (fall_p1 && state == ST_RUN) begin
                if (bit_cnt < CNT_MAX) begin
                    sd_out    <= shift_reg[DATA_WIDTH-1];
                    shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                end else begin
                    sd_out <= 1'b0;
                end
                bit_cnt <= sat_inc(bit_cnt);
            end
        end
    end

endmodule

// File: tb/tb_i2s_sync_transmitter.sv
// Bench for i2s_sync_transmitter: plays the codec (bit clock and word select),
// sources sample pairs through the handshake interface and predicts every
// serial bit and every frame_start/underrun pulse from slot-level rules.
module tb_i2s_sync_transmitter;

    localparam int DW   = 24;
    localparam int SYNC = 2;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        longint        t;
    } pair_t;

    logic clock  = 1'b0;
    logic reset  = 1'b0;
    logic sck_in = 1'b1;
    logic ws_in  = 1'b1;
    logic sd_out;
    logic frame_start;
    logic underrun;

    i2s_sync_transmitter_if #(.DATA_WIDTH(DW)) bus ();

    i2s_sync_transmitter #(
        .DATA_WIDTH (DW),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sck_in     (sck_in),
        .ws_in      (ws_in),
        .sample_bus (bus),
        .sd_out     (sd_out),
        .frame_start(frame_start),
        .underrun   (underrun)
    );

    always #10 clock = ~clock;

    int     checks   = 0;
    int     failures = 0;
    int     fs_seen  = 0;
    int     ur_seen  = 0;
    longint fs_time  = 0;

    pair_t src_q[$];
    pair_t acc_q[$];

    // Slot-level reference state
    bit            m_armed   = 1'b0;
    bit            m_run     = 1'b0;
    bit            m_ws_prev = 1'b0;
    logic [DW-1:0] m_word    = '0;
    logic [DW-1:0] m_right   = '0;
    int            m_bit     = 0;
    int            exp_fs    = 0;
    int            exp_ur    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample source: offers the queue head, logs each accepted pair with its time.
    initial begin
        bit    acc;
        pair_t p;
        bus.in_valid = 1'b0;
        bus.in_left  = '0;
        bus.in_right = '0;
        forever begin
            @(negedge clock);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clock);
            #1;
            if (acc && src_q.size() > 0) begin
                p   = src_q.pop_front();
                p.t = $time;
                acc_q.push_back(p);
            end
            if (src_q.size() > 0) begin
                bus.in_valid = 1'b1;
                bus.in_left  = src_q[0].l;
                bus.in_right = src_q[0].r;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
    end

    // Pulse monitor: every high cycle counts as one pulse.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (frame_start === 1'b1) begin
                fs_seen++;
                fs_time = $time;
            end
            if (underrun === 1'b1)
                ur_seen++;
        end
    end

    task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
        pair_t p;
        p.l = l;
        p.r = r;
        p.t = 0;
        src_q.push_back(p);
    endtask

    // One bit-clock period: falling edge with new ws, check data, rising edge.
    task automatic bclk(input logic w);
        logic  exp;
        pair_t p;
        sck_in = 1'b0;
        ws_in  = w;
        exp = (m_run && m_bit < DW) ? m_word[DW-1-m_bit] : 1'b0;
        if (m_run)
            m_bit++;
        #140;
        chk("sd_bit", {31'd0, sd_out}, {31'd0, exp});
        sck_in = 1'b1;
        if (!m_armed) begin
            m_armed   = 1'b1;
            m_ws_prev = w;
        end else if (w != m_ws_prev) begin
            m_ws_prev = w;
            m_run     = 1'b1;
            m_bit     = 0;
            if (w == 1'b0) begin
                exp_fs++;
                if (acc_q.size() > 0 && acc_q[0].t < $time) begin
                    p       = acc_q.pop_front();
                    m_word  = p.l;
                    m_right = p.r;
                end else begin
                    m_word  = '0;
                    m_right = '0;
                    exp_ur++;
                end
            end else begin
                m_word = m_right;
            end
        end
        #160;
    endtask

    task automatic frame(input int len);
        for (int i = 0; i < len; i++) bclk(1'b0);
        for (int i = 0; i < len; i++) bclk(1'b1);
    endtask

    task automatic do_reset(input bit check_next);
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_armed = 1'b0;
        m_run   = 1'b0;
        m_word  = '0;
        m_right = '0;
        m_bit   = 0;
        acc_q.delete();
        @(posedge clock);
        #1;
        if (check_next)
            chk("rst_sd_next_cycle", {31'd0, sd_out}, 32'd0);
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int     fs0;
        int     ur0;
        int     len;
        longint diff;

        // Reset state
        do_reset(1'b0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_sd_out", {31'd0, sd_out}, 32'd0);
        chk("rst_frame_start", {31'd0, frame_start}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);

        // Basic frame
        push(24'hA5A5A5, 24'h123456);
        for (int i = 0; i < 4; i++) bclk(1'b1);
        chk("basic_accepted", acc_q.size(), 32'd1);
        fs0 = fs_seen;
        ur0 = ur_seen;
        frame(32);
        chk("basic_fs_once", fs_seen - fs0, 32'd1);
        chk("basic_no_underrun", ur_seen - ur0, 32'd0);

        // Underrun: three empty frames
        fs0 = fs_seen;
        ur0 = ur_seen;
        for (int f = 0; f < 3; f++) frame(32);
        chk("underrun_count", ur_seen - ur0, 32'd3);
        chk("underrun_fs_count", fs_seen - fs0, 32'd3);
        chk("underrun_model_ur", ur_seen, exp_ur);

        // Backpressure with two pairs offered back to back
        push(24'($urandom), 24'($urandom));
        push(24'($urandom), 24'($urandom));
        repeat (3) @(posedge clock);
        #1;
        chk("bp_first_accept", acc_q.size(), 32'd1);
        chk("bp_ready_low", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_second_waiting", {31'd0, bus.in_valid}, 32'd1);
        ur0 = ur_seen;
        frame(32);
        chk("bp_second_accept", acc_q.size(), 32'd1);
        diff = (acc_q.size() > 0) ? acc_q[0].t - fs_time : 64'd0;
        chk("bp_accept_after_load", 32'(diff), 32'd20);
        frame(32);
        chk("bp_no_underrun", ur_seen - ur0, 32'd0);
        frame(32);
        chk("bp_underrun_after", ur_seen - ur0, 32'd1);

        // Reset in the middle of a left slot
        push(24'hFFFFFF, 24'($urandom));
        for (int i = 0; i < 12; i++) bclk(1'b0);
        do_reset(1'b1);
        fs0 = fs_seen;
        ur0 = ur_seen;
        for (int i = 0; i < 20; i++) bclk(1'b0);
        for (int i = 0; i < 32; i++) bclk(1'b1);
        chk("rst_no_fs_yet", fs_seen - fs0, 32'd0);
        frame(32);
        chk("rst_first_left_underrun", ur_seen - ur0, 32'd1);
        chk("rst_in_ready_after", {31'd0, bus.in_ready}, 32'd1);

        // Short slots of 16 bit clocks
        push(24'hFFFF00, 24'($urandom));
        repeat (3) @(posedge clock);
        #1;
        frame(16);
        frame(16);

        // Negative full-scale left sample
        push(24'h800001, 24'($urandom));
        repeat (3) @(posedge clock);
        #1;
        ur0 = ur_seen;
        frame(32);
        chk("neg_no_underrun", ur_seen - ur0, 32'd0);

        // Random pairs, random presence, random slot lengths
        for (int f = 0; f < 6; f++) begin
            if ($urandom_range(0, 1) == 1)
                push(24'($urandom), 24'($urandom));
            len = $urandom_range(12, 32);
            frame(len);
        end

        // Flush the last right-slot bit and compare pulse totals
        bclk(1'b0);
        chk("total_frame_start", fs_seen, exp_fs);
        chk("total_underrun", ur_seen, exp_ur);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
